uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 18 +
 rtl/tx_timer.sv | 30 +++
 rtl/uart_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Line levels: the stop bit level doubles as the idle (mark) level.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_timer.sv
// rtl/tx_timer.sv - rollover counter with clear and enable used for bit timing
module tx_timer #(
  parameter int MAX_COUNT = 9,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);

  logic at_max;

  assign at_max   = (count == WIDTH'(MAX_COUNT));
  assign rollover = enable && at_max;

  // Count up while enabled, wrap after MAX_COUNT; clear has priority.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with a one-entry holding buffer
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 write_en,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 clear_error,
  output logic                 serial_out,
  output logic                 buffer_full,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 overrun_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  tx_state_t            state;
  tx_state_t            next_state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] next_shift;
  logic [DATA_BITS-1:0] buffer_data;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     next_bit_cnt;
  logic [CNT_W-1:0]     baud_count;
  logic                 bit_done;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 drain;
  logic                 accept;
  logic                 overrun_set;
  logic                 next_line;
  logic                 done_next;

  // The baud counter restarts on every state entry and only runs mid-frame.
  assign timer_clear  = (next_state != state);
  assign timer_enable = (state != IDLE);

  tx_timer #(
    .MAX_COUNT (CLKS_PER_BIT - 1),
    .WIDTH     (CNT_W)
  ) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .count    (baud_count),
    .rollover (bit_done)
  );

  // A write is taken when the buffer is empty or is being emptied this cycle.
  assign accept      = write_en && (!buffer_full || drain);
  assign overrun_set = write_en && buffer_full && !drain;

  // tx_done is registered, so raise it one cycle early to land on the last stop cycle.
  assign done_next = (state == STOP) && (baud_count == CNT_W'(CLKS_PER_BIT - 2));

  // Next-state, shift register and bit counter logic.
  always_comb begin
    next_state   = state;
    next_shift   = shift_reg;
    next_bit_cnt = bit_cnt;
    drain        = 1'b0;
    case (state)
      IDLE: begin
        if (buffer_full) begin
          drain      = 1'b1;
          next_shift = buffer_data;
          next_state = START;
        end
      end
      START: begin
        if (bit_done) begin
          next_bit_cnt = '0;
          next_state   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          next_shift   = shift_reg >> 1;
          next_bit_cnt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (buffer_full) begin
            drain      = 1'b1;
            next_shift = buffer_data;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, so serial_out can be a plain register.
  always_comb begin
    next_line = STOP_BIT;
    case (next_state)
      IDLE:    next_line = STOP_BIT;
      START:   next_line = START_BIT;
      DATA:    next_line = next_shift[0];
      STOP:    next_line = STOP_BIT;
      default: next_line = STOP_BIT;
    endcase
  end

  // Frame state and registered line/status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= STOP_BIT;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= next_state;
      shift_reg  <= next_shift;
      bit_cnt    <= next_bit_cnt;
      serial_out <= next_line;
      tx_busy    <= (next_state != IDLE);
      tx_done    <= done_next;
    end
  end

  // Holding buffer and sticky overrun flag; a new overrun beats clear_error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buffer_full   <= 1'b0;
      buffer_data   <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (accept) begin
        buffer_full <= 1'b1;
        buffer_data <= write_data;
      end else if (drain) begin
        buffer_full <= 1'b0;
      end
      if (overrun_set) begin
        overrun_error <= 1'b1;
      end else if (clear_error) begin
        overrun_error <= 1'b0;
      end
    end
  end

endmodule
